// File: rtl/fifo_sync_prot.sv
// Single-clock FIFO with occupancy count, programmable almost flags, optional
// first-word-fall-through read and per-word parity with sticky error status.
module fifo_sync_prot #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  ParityInject,
  input  logic                  ReadEn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic [CW-1:0]         Count,
  input  logic [CW-1:0]         AeThresh,
  input  logic [CW-1:0]         AfThresh,
  output logic                  Empty_,
  output logic                  AlmostEmpty_,
  output logic                  HalfFull_,
  output logic                  AlmostFull_,
  output logic                  Full_,
  output logic [2:0]            ErrStatus,
  input  logic                  ErrClear,
  output logic                  Error_
);

  localparam int unsigned AW = CW - 1;
  localparam int unsigned MW = DATA_WIDTH + 1;

  logic [MW-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0] wp;
  logic [CW-1:0] rp;
  logic [CW-1:0] count;
  logic [2:0]    err;

  logic          rd_ok_c;
  logic          wr_ok_c;
  logic          wr_rej_c;
  logic          rd_rej_c;
  logic          par_err_c;
  logic [MW-1:0] head_c;
  logic [2:0]    err_new_c;

  // Acceptance: a write into a full FIFO is allowed only alongside a pop
  assign rd_ok_c   = ReadEn && (count != '0);
  assign wr_ok_c   = WriteEn && ((count < CW'(FIFO_DEPTH)) || rd_ok_c);
  assign wr_rej_c  = WriteEn && !wr_ok_c;
  assign rd_rej_c  = ReadEn && !rd_ok_c;

  // Stored word carries its parity bit, so XOR over the word is 0 when intact
  assign head_c    = mem[rp[AW-1:0]];
  assign par_err_c = rd_ok_c && (^head_c);
  assign err_new_c = {par_err_c, rd_rej_c, wr_rej_c};

  // Storage is not reset
  always_ff @(posedge Clock) begin
    if (wr_ok_c) begin
      mem[wp[AW-1:0]] <= {(^DataIn) ^ ParityInject, DataIn};
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok_c) wp <= wp + CW'(1);
      if (rd_ok_c) rp <= rp + CW'(1);
      unique case ({wr_ok_c, rd_ok_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a fresh error wins over a simultaneous clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err <= '0;
    end else begin
      err <= (ErrClear ? 3'b000 : err) | err_new_c;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign DataOut   = head_c[DATA_WIDTH-1:0];
      assign DataValid = (count != '0);
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dv_q;

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= rd_ok_c;
          if (rd_ok_c) dout_q <= head_c[DATA_WIDTH-1:0];
        end
      end

      assign DataOut   = dout_q;
      assign DataValid = dv_q;
    end
  endgenerate

  // Flags decode the registered count against live thresholds
  assign Count        = count;
  assign Empty_       = !(count == '0);
  assign Full_        = !(count == CW'(FIFO_DEPTH));
  assign HalfFull_    = !(count >= CW'(FIFO_DEPTH / 2));
  assign AlmostEmpty_ = !(count <= AeThresh);
  assign AlmostFull_  = !(count >= AfThresh);
  assign ErrStatus    = err;
  assign Error_       = ~|err;

endmodule

// File: tb/tb_fifo_sync_prot.sv
// Directed bench for fifo_sync_prot: a vector table for the standard-mode
// instance plus hand-written wrap, reset and FWFT sequences.
module tb_fifo_sync_prot;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          we, re, pinj, eclr;
  logic [DW-1:0] din;
  logic [CW-1:0] ae, af;
  logic [DW-1:0] dout;
  logic          dv;
  logic [CW-1:0] cnt;
  logic          e_n, ae_n, hf_n, af_n, f_n, err_n;
  logic [2:0]    err;

  logic          f_we, f_re, f_pinj, f_eclr;
  logic [DW-1:0] f_din, f_dout;
  logic          f_dv;
  logic [CW-1:0] f_cnt;
  logic          f_e_n, f_ae_n, f_hf_n, f_af_n, f_f_n, f_err_n;
  logic [2:0]    f_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  fifo_sync_prot #(.FIFO_DEPTH(16), .DATA_WIDTH(DW), .FWFT(1'b0)) dut (
    .Clock(Clock), .Reset(Reset), .WriteEn(we), .DataIn(din), .ParityInject(pinj),
    .ReadEn(re), .DataOut(dout), .DataValid(dv), .Count(cnt), .AeThresh(ae),
    .AfThresh(af), .Empty_(e_n), .AlmostEmpty_(ae_n), .HalfFull_(hf_n),
    .AlmostFull_(af_n), .Full_(f_n), .ErrStatus(err), .ErrClear(eclr), .Error_(err_n)
  );

  fifo_sync_prot #(.FIFO_DEPTH(16), .DATA_WIDTH(DW), .FWFT(1'b1)) dut_fwft (
    .Clock(Clock), .Reset(Reset), .WriteEn(f_we), .DataIn(f_din), .ParityInject(f_pinj),
    .ReadEn(f_re), .DataOut(f_dout), .DataValid(f_dv), .Count(f_cnt), .AeThresh(ae),
    .AfThresh(af), .Empty_(f_e_n), .AlmostEmpty_(f_ae_n), .HalfFull_(f_hf_n),
    .AlmostFull_(f_af_n), .Full_(f_f_n), .ErrStatus(f_err), .ErrClear(f_eclr),
    .Error_(f_err_n)
  );

  typedef struct {
    logic          we;
    logic [DW-1:0] din;
    logic          pinj;
    logic          re;
    logic          eclr;
    int            cnt;
    logic          chk_dout;
    logic [DW-1:0] dout;
    logic          dv;
    logic [2:0]    err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flags for AeThresh=2, AfThresh=14, depth 16: {Empty_,AlmostEmpty_,HalfFull_,AlmostFull_,Full_}
  function automatic logic [4:0] flags_for(input int c);
    return {c != 0, c > 2, c < 8, c < 14, c != 16};
  endfunction

  function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic pi,
                              input logic r, input logic ec, input int c,
                              input logic cd, input logic [DW-1:0] o,
                              input logic v, input logic [2:0] e);
    vec_t x;
    x.we = w; x.din = d; x.pinj = pi; x.re = r; x.eclr = ec; x.cnt = c;
    x.chk_dout = cd; x.dout = o; x.dv = v; x.err = e;
    return x;
  endfunction

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re = 0; pinj = 0; eclr = 0; din = '0;
    f_we = 0; f_re = 0; f_pinj = 0; f_eclr = 0; f_din = '0;
  endtask

  task automatic chk_std(input string tag, input int c, input logic [2:0] e);
    chk({tag, " count"}, 64'(cnt), 64'(c));
    chk({tag, " flags"}, 64'({e_n, ae_n, hf_n, af_n, f_n}), 64'(flags_for(c)));
    chk({tag, " err"}, 64'(err), 64'(e));
    chk({tag, " error_n"}, 64'(err_n), 64'(~|e));
  endtask

  int          q[$];
  logic [DW-1:0] exp_word;

  initial begin
    idle_inputs();
    ae = CW'(2);
    af = CW'(14);
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk_std("reset", 0, 3'b000);
    chk("reset dout", 64'(dout), 64'd0);
    chk("reset dv", 64'(dv), 64'd0);
    chk("reset fwft count", 64'(f_cnt), 64'd0);
    chk("reset fwft dv", 64'(f_dv), 64'd0);
    Reset = 1'b0;

    // Fill, overflow, simultaneous access at full, drain, underflow, parity
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, DW'(i), 0, 0, 0, i + 1, 0, '0, 0, 3'b000));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 16, 0, '0, 0, 3'b001));
    vecs.push_back(mk(0, '0, 0, 0, 1, 16, 0, '0, 0, 3'b000));
    vecs.push_back(mk(1, 32'hAA, 0, 1, 0, 16, 1, 32'h0, 1, 3'b000));
    for (int i = 1; i < 16; i++) vecs.push_back(mk(0, '0, 0, 1, 0, 16 - i, 1, DW'(i), 1, 3'b000));
    vecs.push_back(mk(0, '0, 0, 1, 0, 0, 1, 32'hAA, 1, 3'b000));
    vecs.push_back(mk(0, '0, 0, 1, 0, 0, 1, 32'hAA, 0, 3'b010));
    vecs.push_back(mk(0, '0, 0, 0, 1, 0, 0, '0, 0, 3'b000));
    vecs.push_back(mk(1, 32'h55, 0, 1, 0, 1, 1, 32'hAA, 0, 3'b010));
    vecs.push_back(mk(0, '0, 0, 1, 1, 0, 1, 32'h55, 1, 3'b000));
    vecs.push_back(mk(1, 32'hA5A5A5A5, 1, 0, 0, 1, 0, '0, 0, 3'b000));
    vecs.push_back(mk(0, '0, 0, 1, 0, 0, 1, 32'hA5A5A5A5, 1, 3'b100));
    vecs.push_back(mk(0, '0, 0, 0, 0, 0, 0, '0, 0, 3'b100));
    vecs.push_back(mk(0, '0, 0, 0, 1, 0, 0, '0, 0, 3'b000));
    vecs.push_back(mk(1, 32'h3C, 0, 0, 0, 1, 0, '0, 0, 3'b000));
    vecs.push_back(mk(0, '0, 0, 1, 0, 0, 1, 32'h3C, 1, 3'b000));
    vecs.push_back(mk(0, '0, 0, 1, 0, 0, 1, 32'h3C, 0, 3'b010));
    vecs.push_back(mk(0, '0, 0, 1, 1, 0, 1, 32'h3C, 0, 3'b010));
    vecs.push_back(mk(0, '0, 0, 0, 1, 0, 0, '0, 0, 3'b000));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      we = vecs[i].we; din = vecs[i].din; pinj = vecs[i].pinj;
      re = vecs[i].re; eclr = vecs[i].eclr;
      cyc();
      chk_std(tag, vecs[i].cnt, vecs[i].err);
      chk({tag, " dv"}, 64'(dv), 64'(vecs[i].dv));
      if (vecs[i].chk_dout) chk({tag, " dout"}, 64'(dout), 64'(vecs[i].dout));
    end
    idle_inputs();

    // Wrap-around: 20 writes and 20 reads, interleaved, against a queue model
    for (int k = 0; k < 23; k++) begin
      we = (k < 20);
      din = 32'hC000 + DW'(k);
      re = (k >= 3);
      cyc();
      if (we) q.push_back(int'(din));
      if (re) begin
        exp_word = DW'(q.pop_front());
        chk($sformatf("wrap%0d dout", k), 64'(dout), 64'(exp_word));
        chk($sformatf("wrap%0d dv", k), 64'(dv), 64'd1);
      end
      chk($sformatf("wrap%0d count", k), 64'(cnt), 64'(q.size()));
    end
    idle_inputs();
    chk("wrap err", 64'(err), 64'd0);

    // Reset mid-stream with Count=5 and a pending underflow error
    re = 1; cyc(); re = 0;
    for (int k = 0; k < 5; k++) begin
      we = 1; din = 32'hD0 + DW'(k); cyc();
    end
    we = 0;
    chk_std("pre-reset", 5, 3'b010);
    #2 Reset = 1'b1;
    #1;
    chk_std("async reset", 0, 3'b000);
    chk("async reset dv", 64'(dv), 64'd0);
    chk("async reset dout", 64'(dout), 64'd0);
    cyc();
    Reset = 1'b0;
    we = 1; din = 32'h77; cyc();
    we = 0; re = 1; cyc();
    re = 0;
    chk("post-reset dout", 64'(dout), 64'h77);
    chk("post-reset dv", 64'(dv), 64'd1);
    chk_std("post-reset", 0, 3'b000);

    // FWFT: head word visible one cycle after its write, ReadEn pops it
    f_we = 1; f_din = 32'h1234; cyc();
    f_we = 0;
    chk("fwft dout", 64'(f_dout), 64'h1234);
    chk("fwft dv", 64'(f_dv), 64'd1);
    chk("fwft count", 64'(f_cnt), 64'd1);
    cyc();
    chk("fwft hold dv", 64'(f_dv), 64'd1);
    f_re = 1; cyc();
    f_re = 0;
    chk("fwft pop count", 64'(f_cnt), 64'd0);
    chk("fwft pop dv", 64'(f_dv), 64'd0);
    chk("fwft pop err", 64'(f_err), 64'd0);
    f_we = 1; f_din = 32'h0F0F0F0F; f_pinj = 1; cyc();
    f_we = 0; f_pinj = 0;
    chk("fwft second dout", 64'(f_dout), 64'h0F0F0F0F);
    f_re = 1; cyc();
    f_re = 0;
    chk("fwft parity err", 64'(f_err), 64'b100);
    chk("fwft error_n", 64'(f_err_n), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
